// File: rtl/reg_transfer_seq.sv
// Register-unit transfer sequencer: for each command it drives select/ALU strobes,
// then a load strobe, then a select hold. Optional feature macro: MOV_SELF_CLEAR_EN.
module reg_transfer_seq #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned LOAD_CYC   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  output logic       busy,
  output logic [7:0] sel,
  output logic [7:0] ld,
  output logic       alu_en,
  output logic [2:0] alu_fn,
  output logic       done,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_LOAD, S_RELEASE, S_DONE, S_ILLEGAL
  } state_e;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] LOAD_LD   = 4'(LOAD_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] instr_q, instr_d;

  logic       is_mov_d, is_alu_d, drive_d, clr_d;
  logic [2:0] src_d, dst_d;
  logic       busy_d, alu_en_d, done_d, illegal_d;
  logic [7:0] sel_d, ld_d;
  logic [2:0] alu_fn_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    if (state_q == S_IDLE && start) instr_d = instr;

    is_mov_d = (instr_d[7:6] == 2'b00);
    is_alu_d = (instr_d[7:4] == 4'b1000);
    src_d    = instr_d[2:0];
    dst_d    = is_mov_d ? instr_d[5:3] : (instr_d[3] ? 3'd3 : 3'd0);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_mov_d || is_alu_d) begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_LD;
          end else begin
            state_d = S_ILLEGAL;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_LOAD;
          cnt_d   = LOAD_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_LOAD: begin
        if (cnt_q == '0) state_d = S_RELEASE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_RELEASE: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_ILLEGAL: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    drive_d = (state_d == S_SETTLE) || (state_d == S_LOAD) || (state_d == S_RELEASE);
`ifdef MOV_SELF_CLEAR_EN
    clr_d = (src_d == dst_d);
`else
    clr_d = 1'b0;
`endif
    busy_d    = (state_d != S_IDLE);
    sel_d     = (drive_d && is_mov_d && !clr_d) ? (8'd1 << src_d) : '0;
    alu_en_d  = drive_d && is_alu_d;
    alu_fn_d  = (drive_d && is_alu_d) ? instr_d[2:0] : '0;
    ld_d      = (state_d == S_LOAD) ? (8'd1 << dst_d) : '0;
    done_d    = (state_d == S_DONE);
    illegal_d = (state_d == S_ILLEGAL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      busy    <= 1'b0;
      sel     <= '0;
      ld      <= '0;
      alu_en  <= 1'b0;
      alu_fn  <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      busy    <= busy_d;
      sel     <= sel_d;
      ld      <= ld_d;
      alu_en  <= alu_en_d;
      alu_fn  <= alu_fn_d;
      done    <= done_d;
      illegal <= illegal_d;
    end
  end

endmodule

// File: tb/tb_reg_transfer_seq.sv
// Bench for reg_transfer_seq: default instance plus a SETTLE=4/LOAD=3 instance,
// both checked cycle by cycle against a schedule-based reference model.
module tb_reg_transfer_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_r = 1'b0;
  logic [7:0] instr_r = '0;
  int         dut_sel = 0;

  logic       busy1, alu_en1, done1, illegal1;
  logic [7:0] sel1, ld1;
  logic [2:0] alu_fn1;
  logic       busy2, alu_en2, done2, illegal2;
  logic [7:0] sel2, ld2;
  logic [2:0] alu_fn2;

  logic start1, start2;
  assign start1 = start_r && (dut_sel == 0);
  assign start2 = start_r && (dut_sel == 1);

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  reg_transfer_seq dut1 (
    .clk(clk), .reset(reset), .start(start1), .instr(instr_r),
    .busy(busy1), .sel(sel1), .ld(ld1), .alu_en(alu_en1), .alu_fn(alu_fn1),
    .done(done1), .illegal(illegal1)
  );

  reg_transfer_seq #(.SETTLE_CYC(4), .LOAD_CYC(3)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .instr(instr_r),
    .busy(busy2), .sel(sel2), .ld(ld2), .alu_en(alu_en2), .alu_fn(alu_fn2),
    .done(done2), .illegal(illegal2)
  );

  // {busy, sel, ld, alu_en, alu_fn, done, illegal}
  function automatic logic [22:0] obs();
    if (dut_sel == 1) return {busy2, sel2, ld2, alu_en2, alu_fn2, done2, illegal2};
    return {busy1, sel1, ld1, alu_en1, alu_fn1, done1, illegal1};
  endfunction

  function automatic int cur_s();
    return (dut_sel == 1) ? 4 : 2;
  endfunction

  function automatic int cur_l();
    return (dut_sel == 1) ? 3 : 1;
  endfunction

  function automatic bit legal(input logic [7:0] ins);
    return (ins[7:6] == 2'b00) || (ins[7:4] == 4'b1000);
  endfunction

  // Cycles from acceptance until the sequencer is back in idle (inclusive).
  function automatic int txn_len(input logic [7:0] ins, input int s, input int l);
    return legal(ins) ? s + l + 3 : 2;
  endfunction

  // Expected outputs k cycles after the cycle in which the command was accepted.
  function automatic logic [22:0] exp_vec(input logic [7:0] ins, input int k,
                                          input int s, input int l);
    logic       b, ae, d, il, mov, drive, loadw, selfclr;
    logic [7:0] sv, lv;
    logic [2:0] fn;
    int         src, dst;
    b = 0; ae = 0; d = 0; il = 0; sv = '0; lv = '0; fn = '0;
    mov = (ins[7:6] == 2'b00);
    src = int'(ins[2:0]);
    dst = mov ? int'(ins[5:3]) : (ins[3] ? 3 : 0);
`ifdef MOV_SELF_CLEAR_EN
    selfclr = (src == dst);
`else
    selfclr = 0;
`endif
    if (!legal(ins)) begin
      il = (k == 1);
      b  = (k == 1);
    end else begin
      b     = (k >= 1) && (k <= s + l + 2);
      drive = (k >= 1) && (k <= s + l + 1);
      loadw = (k >= s + 1) && (k <= s + l);
      d     = (k == s + l + 2);
      if (mov) begin
        if (drive && !selfclr) sv[src] = 1'b1;
      end else begin
        ae = drive;
        if (drive) fn = ins[2:0];
      end
      if (loadw) lv[dst] = 1'b1;
    end
    return {b, sv, lv, ae, fn, d, il};
  endfunction

  // Called at a negedge: presents the command in this cycle, checks every following
  // cycle through the return to idle. junk=1 keeps start high with random bytes while busy.
  task automatic run_txn(input logic [7:0] ins, input bit junk, input string name);
    int s, l, n;
    logic [22:0] e, o;
    s = cur_s(); l = cur_l();
    n = txn_len(ins, s, l);
    start_r = 1'b1;
    instr_r = ins;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      e = exp_vec(ins, k, s, l);
      o = obs();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL %s k=%0d instr=%02h got=%06h exp=%06h", name, k, ins, o, e);
      end
      if (junk && k < n) begin
        start_r = 1'b1;
        instr_r = 8'($urandom);
      end else begin
        start_r = 1'b0;
      end
    end
  endtask

  task automatic check_zero(input string name, input int cycles);
    logic [22:0] o;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      o = obs();
      compared++;
      if (o !== '0) begin
        mismatched++;
        $display("FAIL %s k=%0d got=%06h exp=000000", name, k, o);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_r = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_zero("reset_idle", 3);
  endtask

  task automatic test_mov();
    run_txn(8'h0B, 1'b0, "mov_b_from_d");
    run_txn(8'h3E, 1'b0, "mov_y_from_x");
  endtask

  task automatic test_alu();
    run_txn(8'h85, 1'b0, "alu_fn5_a");
    run_txn(8'h8F, 1'b0, "alu_fn7_d");
  endtask

  task automatic test_illegal_then_start();
    run_txn(8'hC3, 1'b0, "illegal_c3");
    run_txn(8'h8D, 1'b0, "after_illegal_8d");
  endtask

  task automatic test_busy_ignore();
    run_txn(8'h1A, 1'b1, "busy_start_ignored");
  endtask

  task automatic test_back_to_back();
    run_txn(8'h0B, 1'b0, "b2b_first");
    run_txn(8'h21, 1'b0, "b2b_second");
  endtask

  task automatic test_abort();
    logic [22:0] o, e;
    start_r = 1'b1;
    instr_r = 8'h01;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      e = exp_vec(8'h01, k, cur_s(), cur_l());
      o = obs();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL abort_pre k=%0d got=%06h exp=%06h", k, o, e);
      end
      start_r = (k == 2);
      instr_r = (k == 2) ? 8'h85 : 8'h01;
      if (k == 3) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    o = obs();
    compared++;
    if (o !== '0) begin
      mismatched++;
      $display("FAIL abort_reset got=%06h exp=000000", o);
    end
    check_zero("abort_no_done", 4);
    reset = 1'b1;
    start_r = 1'b1;
    instr_r = 8'h0B;
    @(negedge clk);
    reset = 1'b0;
    start_r = 1'b0;
    check_zero("reset_start_same", 2);
  endtask

  task automatic test_self_move();
    run_txn(8'h12, 1'b0, "self_move_c");
  endtask

  task automatic test_params();
    dut_sel = 1;
    run_txn(8'h0B, 1'b0, "long_mov");
    run_txn(8'h8A, 1'b0, "long_alu");
    run_txn(8'hFF, 1'b0, "long_illegal");
    run_txn(8'h2D, 1'b1, "long_mov_junk");
    dut_sel = 0;
  endtask

  task automatic test_random();
    logic [7:0] ins;
    for (int t = 0; t < 60; t++) begin
      dut_sel = (t % 3 == 2) ? 1 : 0;
      case ($urandom_range(0, 2))
        0:       ins = {2'b00, 6'($urandom)};
        1:       ins = {4'b1000, 4'($urandom)};
        default: ins = 8'($urandom);
      endcase
      run_txn(ins, 1'($urandom), "random");
      if ($urandom_range(0, 1) == 1) check_zero("random_gap", $urandom_range(1, 3));
    end
    dut_sel = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mov();
    test_alu();
    test_illegal_then_start();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    test_self_move();
    test_params();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
